// File: rtl/w80386dx_pkg.sv
// Purpose : shared code-byte types and prefetch sizing constants for the fetch/decode path.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package w80386dx_pkg;
  typedef logic [7:0] code_byte_t;
  typedef code_byte_t [0:3] instr_window_t;

  localparam int PREFETCH_DEPTH_BYTES = 16;
  localparam int WINDOW_BYTES         = 4;
endpackage

// File: rtl/prefetch_queue_if.sv
// Purpose : fetch-side and decode-side signal bundle of the prefetch queue.
// Latency : n/a (wiring only).
// Backpr. : fetch stalls on o_fetch_ready; decode paces itself via i_consume.
// Ports   : i_fetch_valid/i_fetch_data/i_fetch_offset/o_fetch_ready (fetch dword in),
//           o_instruction/o_valid_bytes/i_consume (decode window), i_flush, o_error.
//           slave = the queue, master = fetch/decode environment.
interface prefetch_queue_if;
  import w80386dx_pkg::*;

  logic          i_fetch_valid;
  logic [31:0]   i_fetch_data;
  logic [1:0]    i_fetch_offset;
  logic          o_fetch_ready;
  instr_window_t o_instruction;
  logic [2:0]    o_valid_bytes;
  logic [2:0]    i_consume;
  logic          i_flush;
  logic          o_error;

  modport master (
    output i_fetch_valid, i_fetch_data, i_fetch_offset, i_consume, i_flush,
    input  o_fetch_ready, o_instruction, o_valid_bytes, o_error
  );

  modport slave (
    input  i_fetch_valid, i_fetch_data, i_fetch_offset, i_consume, i_flush,
    output o_fetch_ready, o_instruction, o_valid_bytes, o_error
  );
endinterface

// File: rtl/prefetch_window_mux.sv
// Purpose : selects the 4-byte decode window from the byte ring (oldest byte first), zero-masking empty slots.
// Latency : combinational.
// Backpr. : none; reports how many window bytes are valid.
// Ports   : arr/rd_ptr/count from the queue state; window/valid_bytes to decode.
//           With PREFETCH_QUEUE_BYPASS_EN defined, an empty queue forwards the incoming
//           fetch dword (offset-aligned) straight into the window in the same cycle.
module prefetch_window_mux
  import w80386dx_pkg::*;
#(
  parameter int DEPTH_BYTES = 16,
  parameter int PTR_W       = $clog2(DEPTH_BYTES)
) (
  input  code_byte_t [DEPTH_BYTES-1:0] arr,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic [PTR_W:0]               count,
`ifdef PREFETCH_QUEUE_BYPASS_EN
  input  logic                         wr_fire,
  input  logic [31:0]                  fetch_data,
  input  logic [1:0]                   fetch_offset,
`endif
  output instr_window_t                window,
  output logic [2:0]                   valid_bytes
);
`ifdef PREFETCH_QUEUE_BYPASS_EN
  logic [31:0] aligned;
  // Shifting out the skipped bytes leaves zeros above the valid ones for free.
  assign aligned = fetch_data >> {fetch_offset, 3'b000};
`endif

  always_comb begin
    window      = '0;
    valid_bytes = (count > (PTR_W+1)'(3)) ? 3'd4 : count[2:0];
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < valid_bytes)
        window[k] = arr[rd_ptr + PTR_W'(k)];
    end
`ifdef PREFETCH_QUEUE_BYPASS_EN
    if (count == '0 && wr_fire) begin
      valid_bytes = 3'd4 - {1'b0, fetch_offset};
      for (int k = 0; k < 4; k++)
        window[k] = aligned[8*k +: 8];
    end
`endif
  end
endmodule

// File: rtl/prefetch_queue.sv
// Purpose : byte-granular instruction prefetch ring between fetch (32-bit dwords) and decode (4-byte window).
// Latency : 1 cycle fetch-to-window; 0 cycles on an empty queue when PREFETCH_QUEUE_BYPASS_EN is defined.
// Backpr. : o_fetch_ready drops once fewer than a full dword of space is guaranteed, or during flush.
// Ports   : clock, reset (async, active-high), bus (prefetch_queue_if.slave).
module prefetch_queue
  import w80386dx_pkg::*;
#(
  parameter int DEPTH_BYTES  = PREFETCH_DEPTH_BYTES,
  parameter int WINDOW_BYTES = 4
) (
  input  logic             clock,
  input  logic             reset,
  prefetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = PTR_W + 1;

  code_byte_t [DEPTH_BYTES-1:0] mem;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             error_q;

  logic             fetch_ready;
  logic             wr_fire;
  logic             consume_ok;
  logic [2:0]       wr_n;
  logic [2:0]       valid_bytes;
  instr_window_t    window;

  // Ready looks at the pre-consume count so a write can never overrun the ring.
  assign fetch_ready = (count <= CNT_W'(DEPTH_BYTES - WINDOW_BYTES)) & ~bus.i_flush;
  assign wr_fire     = bus.i_fetch_valid & fetch_ready;
  assign wr_n        = 3'd4 - {1'b0, bus.i_fetch_offset};
  assign consume_ok  = bus.i_consume <= valid_bytes;

  assign bus.o_fetch_ready = fetch_ready;
  assign bus.o_instruction = window;
  assign bus.o_valid_bytes = valid_bytes;
  assign bus.o_error       = error_q;

  prefetch_window_mux #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .PTR_W       (PTR_W)
  ) u_window_mux (
    .arr          (mem),
    .rd_ptr       (rd_ptr),
    .count        (count),
`ifdef PREFETCH_QUEUE_BYPASS_EN
    .wr_fire      (wr_fire),
    .fetch_data   (bus.i_fetch_data),
    .fetch_offset (bus.i_fetch_offset),
`endif
    .window       (window),
    .valid_bytes  (valid_bytes)
  );

  // Byte ring: bytes below the offset are dropped, the rest land contiguously at wr_ptr.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(bus.i_fetch_offset))
          mem[wr_ptr + PTR_W'(k - int'(bus.i_fetch_offset))] <= bus.i_fetch_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else if (bus.i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      error_q <= 1'b0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + PTR_W'(wr_n);
      // An over-consume removes nothing; bypassed bytes consumed this cycle
      // cancel out in the count because they were added by the same write.
      if (consume_ok)
        rd_ptr <= rd_ptr + PTR_W'(bus.i_consume);
      else
        error_q <= 1'b1;
      count <= count + (wr_fire ? CNT_W'(wr_n) : '0)
                     - (consume_ok ? CNT_W'(bus.i_consume) : '0);
    end
  end
endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;
  import w80386dx_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fv = 1'b0;
  logic [31:0] fd = '0;
  logic [1:0]  off = '0;
  logic [2:0]  cons = '0;
  logic        fl = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: plain byte queue of stored code bytes plus the sticky error bit.
  logic [7:0] mq[$];
  bit         merr = 1'b0;

  always #5 clock = ~clock;

  prefetch_queue_if bus();
  assign bus.i_fetch_valid  = fv;
  assign bus.i_fetch_data   = fd;
  assign bus.i_fetch_offset = off;
  assign bus.i_consume      = cons;
  assign bus.i_flush        = fl;

  prefetch_queue #(.DEPTH_BYTES(16), .WINDOW_BYTES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic bit m_ready();
    return (mq.size() <= 12) && !fl;
  endfunction

  function automatic bit m_fire();
    return fv && m_ready();
  endfunction

  function automatic bit m_bypass();
`ifdef PREFETCH_QUEUE_BYPASS_EN
    return (mq.size() == 0) && m_fire();
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_valid();
    if (m_bypass()) return 4 - int'(off);
    return (mq.size() > 4) ? 4 : mq.size();
  endfunction

  function automatic logic [7:0] m_byte(int k);
    logic [31:0] d;
    d = fd;
    if (k >= m_valid()) return 8'h00;
    if (m_bypass()) return d[8*(k + int'(off)) +: 8];
    return mq[k];
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input logic [1:0] o,
                       input logic [2:0] c, input bit f);
    fv = v; fd = d; off = o; cons = c; fl = f;
    #1;
  endtask

  // Advance one clock, applying the behavioural rules to the model.
  task automatic tick();
    int  v;
    bit  fire;
    v    = m_valid();
    fire = m_fire();
    @(posedge clock);
    if (fl) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (fire)
        for (int k = int'(off); k < 4; k++) mq.push_back(fd[8*k +: 8]);
      if (int'(cons) <= v) begin
        repeat (int'(cons)) void'(mq.pop_front());
      end else begin
        merr = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.o_fetch_ready); end
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL reset_valid got=%0d want=0", bus.o_valid_bytes); end
    checks++; if (bus.o_instruction !== 32'h0) begin failures++; $display("FAIL reset_window got=%h want=0", bus.o_instruction); end
    checks++; if (bus.o_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", bus.o_error); end
    @(negedge clock);
    reset = 1'b0;
    mq.delete();
    merr = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic [7:0] e[4];
    drive(1, 32'h44332211, 0, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0);
    e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44;
    checks++; if (bus.o_valid_bytes !== 3'd4) begin failures++; $display("FAIL basic_valid got=%0d want=4", bus.o_valid_bytes); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.o_instruction[k] !== e[k]) begin failures++; $display("FAIL basic_win[%0d] got=%h want=%h", k, bus.o_instruction[k], e[k]); end
    end
    drive(0, '0, 0, 3, 0);
    tick();
    drive(0, '0, 0, 0, 0);
    e[0] = 8'h44; e[1] = 8'h00; e[2] = 8'h00; e[3] = 8'h00;
    checks++; if (bus.o_valid_bytes !== 3'd1) begin failures++; $display("FAIL consume3_valid got=%0d want=1", bus.o_valid_bytes); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.o_instruction[k] !== e[k]) begin failures++; $display("FAIL consume3_win[%0d] got=%h want=%h", k, bus.o_instruction[k], e[k]); end
    end
  endtask

  task automatic test_flush_offset();
    drive(1, 32'h12345678, 0, 0, 1);
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", bus.o_fetch_ready); end
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL flush_valid got=%0d want=0", bus.o_valid_bytes); end
    drive(1, 32'hDDCCBBAA, 2, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_valid_bytes !== 3'd2) begin failures++; $display("FAIL offset_valid got=%0d want=2", bus.o_valid_bytes); end
    checks++; if (bus.o_instruction !== {8'hCC, 8'hDD, 8'h00, 8'h00}) begin failures++; $display("FAIL offset_win got=%h want=ccdd0000", bus.o_instruction); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] d[5];
    logic [7:0]  seq[$];
    drive(0, '0, 0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1, d[i], 0, 0, 0);
      tick();
    end
    drive(1, d[4], 0, 0, 0);
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", bus.o_fetch_ready); end
    drive(0, '0, 0, 4, 0);
    tick();
    drive(1, d[4], 0, 0, 0);
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL after_consume_ready got=%b want=1", bus.o_fetch_ready); end
    tick();
    for (int i = 1; i < 5; i++)
      for (int k = 0; k < 4; k++) seq.push_back(d[i][8*k +: 8]);
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 0, 4, 0);
      for (int k = 0; k < 4; k++) begin
        checks++; if (bus.o_instruction[k] !== seq[4*i + k]) begin failures++; $display("FAIL wrap_order[%0d] got=%h want=%h", 4*i + k, bus.o_instruction[k], seq[4*i + k]); end
      end
      tick();
    end
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL wrap_drained got=%0d want=0", bus.o_valid_bytes); end
  endtask

  task automatic test_ready_boundary();
    drive(0, '0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 0, 0, 0);
      tick();
    end
    drive(1, $urandom, 3, 0, 0);
    tick();
    drive(1, $urandom, 0, 0, 0);
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL c13_ready got=%b want=0", bus.o_fetch_ready); end
    tick();
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL c13_held_ready got=%b want=0", bus.o_fetch_ready); end
    drive(1, fd, 0, 1, 0);
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL c13_consume_ready got=%b want=0", bus.o_fetch_ready); end
    tick();
    drive(1, fd, 0, 1, 0);
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL c12_ready got=%b want=1", bus.o_fetch_ready); end
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL c15_ready got=%b want=0", bus.o_fetch_ready); end
    checks++; if (bus.o_valid_bytes !== 3'd4) begin failures++; $display("FAIL c15_valid got=%0d want=4", bus.o_valid_bytes); end
  endtask

  task automatic test_error();
    drive(0, '0, 0, 0, 1);
    tick();
    drive(1, 32'h87654321, 2, 0, 0);
    tick();
    drive(0, '0, 0, 3, 0);
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_error !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", bus.o_error); end
    checks++; if (bus.o_valid_bytes !== 3'd2) begin failures++; $display("FAIL err_nothing_removed got=%0d want=2", bus.o_valid_bytes); end
    checks++; if (bus.o_instruction[0] !== 8'h65) begin failures++; $display("FAIL err_win0 got=%h want=65", bus.o_instruction[0]); end
    tick();
    checks++; if (bus.o_error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", bus.o_error); end
    drive(0, '0, 0, 0, 1);
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_error !== 1'b0) begin failures++; $display("FAIL err_flush_clear got=%b want=0", bus.o_error); end
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL err_flush_valid got=%0d want=0", bus.o_valid_bytes); end
  endtask

  task automatic test_bypass();
    drive(1, 32'h04030201, 0, 4, 0);
`ifdef PREFETCH_QUEUE_BYPASS_EN
    checks++; if (bus.o_valid_bytes !== 3'd4) begin failures++; $display("FAIL bypass_valid got=%0d want=4", bus.o_valid_bytes); end
    checks++; if (bus.o_instruction !== {8'h01, 8'h02, 8'h03, 8'h04}) begin failures++; $display("FAIL bypass_win got=%h want=01020304", bus.o_instruction); end
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d want=0", bus.o_valid_bytes); end
    checks++; if (bus.o_error !== 1'b0) begin failures++; $display("FAIL bypass_error got=%b want=0", bus.o_error); end
`else
    checks++; if (bus.o_valid_bytes !== 3'd0) begin failures++; $display("FAIL nobypass_valid got=%0d want=0", bus.o_valid_bytes); end
    tick();
    drive(0, '0, 0, 0, 0);
    checks++; if (bus.o_error !== 1'b1) begin failures++; $display("FAIL nobypass_error got=%b want=1", bus.o_error); end
    checks++; if (bus.o_valid_bytes !== 3'd4) begin failures++; $display("FAIL nobypass_stored got=%0d want=4", bus.o_valid_bytes); end
`endif
    drive(0, '0, 0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 600; i++) begin
      fv  = ($urandom_range(0, 2) != 0);
      fd  = $urandom;
      off = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 39) == 0);
      cons = 3'd0;
      #1;
      v = m_valid();
      if ($urandom_range(0, 24) == 0) cons = 3'(v + 1);
      else cons = 3'($urandom_range(0, v));
      #1;
      checks++; if (bus.o_fetch_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, bus.o_fetch_ready, m_ready()); end
      checks++; if (int'(bus.o_valid_bytes) != m_valid()) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0d want=%0d", i, bus.o_valid_bytes, m_valid()); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (bus.o_instruction[k] !== m_byte(k)) begin failures++; $display("FAIL rnd_win[%0d] cyc=%0d got=%h want=%h", k, i, bus.o_instruction[k], m_byte(k)); end
      end
      checks++; if (bus.o_error !== merr) begin failures++; $display("FAIL rnd_error cyc=%0d got=%b want=%b", i, bus.o_error, merr); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_offset();
    test_full_wrap();
    test_ready_boundary();
    test_error();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
